// File: rtl/i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_seq_pkg
// Shared definitions for the I2C command sequencer: FSM state encodings,
// frame length and the default 7-bit target address.
// ---------------------------------------------------------------------------
package i2c_seq_pkg;

    // State encodings are visible on the st output (LEDs), so the values
    // are pinned explicitly rather than left to the tool.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ISSUE = 4'd1,
        ST_WAIT  = 4'd2,
        ST_DONE  = 4'd3,
        ST_ERR   = 4'd4
    } seq_state_t;

    localparam int         FRAME_BYTES        = 10;
    localparam logic [3:0] LAST_IDX           = 4'(FRAME_BYTES - 1);
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b0001101;

endpackage

// File: rtl/frame_byte_mux.sv
// ---------------------------------------------------------------------------
// frame_byte_mux
// Purely combinational selection of one byte of the 10-byte I2C frame.
//   frame    in  66  latched command {op[1:0], opA[31:0], opB[31:0]}
//   idx      in  4   byte index 0..9
//   sel_byte out 8   byte to transmit at that index
// Frame layout: address+W, op, opA (MSB first), opB (MSB first).
// ---------------------------------------------------------------------------
module frame_byte_mux
    import i2c_seq_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
    input  logic [65:0] frame,
    input  logic [3:0]  idx,
    output logic [7:0]  sel_byte
);

    // Index 0 never depends on the frame contents, which lets the top
    // select the address byte before the new command has been latched.
    always_comb begin
        sel_byte = 8'h00;
        case (idx)
            4'd0:    sel_byte = {SLAVE_ADDR, 1'b0};
            4'd1:    sel_byte = {6'b000000, frame[65:64]};
            4'd2:    sel_byte = frame[63:56];
            4'd3:    sel_byte = frame[55:48];
            4'd4:    sel_byte = frame[47:40];
            4'd5:    sel_byte = frame[39:32];
            4'd6:    sel_byte = frame[31:24];
            4'd7:    sel_byte = frame[23:16];
            4'd8:    sel_byte = frame[15:8];
            4'd9:    sel_byte = frame[7:0];
            default: sel_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cmd_sequencer
// Turns one 66-bit command into a 10-byte I2C write frame, handing bytes one
// at a time to a byte-level I2C master, with NACK retry and per-byte timeout.
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous active-high reset
//   cmd_in     in   66  {op[1:0], opA[31:0], opB[31:0]}
//   cmd_valid  in   1   cmd_in valid
//   cmd_ready  out  1   high only in IDLE
//   m_req      out  1   one-cycle byte request to the master
//   m_byte     out  8   byte to send (valid with m_req)
//   m_start    out  1   START before this byte (first byte only)
//   m_stop     out  1   STOP after this byte (last byte only)
//   m_done     in   1   master finished the byte
//   m_nack     in   1   target NACKed (valid with m_done)
//   done       out  1   one-cycle frame-complete pulse
//   err        out  1   one-cycle frame-abandoned pulse
//   st         out  4   current state
//   op         out  2   op field of the latched command
// ---------------------------------------------------------------------------
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         MAX_RETRY   = 2,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [65:0] cmd_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        m_req,
    output logic [7:0]  m_byte,
    output logic        m_start,
    output logic        m_stop,
    input  logic        m_done,
    input  logic        m_nack,
    output logic        done,
    output logic        err,
    output logic [3:0]  st,
    output logic [1:0]  op
);

    localparam int             TW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]  TC_LAST     = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     RETRY_LIMIT = 8'(MAX_RETRY);

    seq_state_t    state;
    logic [65:0]   cmd_q;
    logic [3:0]    idx;
    logic [3:0]    nxt_idx;
    logic [7:0]    retries;
    logic [TW-1:0] tcnt;
    logic [7:0]    nxt_byte;

    assign cmd_ready = (state == ST_IDLE);
    assign st        = state;
    assign op        = cmd_q[65:64];

    // Index of the byte about to be issued. m_req/m_byte are registered, so
    // the byte is looked up with the index the FSM is moving to: idx+1 after
    // an ACK, and 0 for both a fresh command and a NACK restart.
    always_comb begin
        nxt_idx = 4'd0;
        if (state == ST_WAIT && m_done && !m_nack && idx != LAST_IDX) begin
            nxt_idx = idx + 4'd1;
        end
    end

    frame_byte_mux #(
        .SLAVE_ADDR(SLAVE_ADDR)
    ) u_frame_byte_mux (
        .frame   (cmd_q),
        .idx     (nxt_idx),
        .sel_byte(nxt_byte)
    );

    // Main sequencer. All pulse outputs default low each cycle and are set
    // on the transition into the state that owns them, so m_req is high for
    // exactly the ISSUE cycle, done for DONE and err for ERR. A reset in the
    // middle of a frame simply drops everything; the master recovers the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cmd_q   <= '0;
            idx     <= 4'd0;
            retries <= 8'd0;
            tcnt    <= '0;
            m_req   <= 1'b0;
            m_byte  <= 8'h00;
            m_start <= 1'b0;
            m_stop  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            m_req   <= 1'b0;
            m_byte  <= 8'h00;
            m_start <= 1'b0;
            m_stop  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q   <= cmd_in;
                        idx     <= 4'd0;
                        retries <= 8'd0;
                        state   <= ST_ISSUE;
                        m_req   <= 1'b1;
                        m_byte  <= nxt_byte;
                        m_start <= 1'b1;
                        m_stop  <= 1'b0;
                    end
                end

                ST_ISSUE: begin
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end

                // m_done wins over a coincident timeout terminal count.
                ST_WAIT: begin
                    if (m_done) begin
                        if (!m_nack) begin
                            if (idx == LAST_IDX) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                idx     <= nxt_idx;
                                state   <= ST_ISSUE;
                                m_req   <= 1'b1;
                                m_byte  <= nxt_byte;
                                m_start <= 1'b0;
                                m_stop  <= (nxt_idx == LAST_IDX);
                            end
                        end else if (retries < RETRY_LIMIT) begin
                            retries <= retries + 8'd1;
                            idx     <= 4'd0;
                            state   <= ST_ISSUE;
                            m_req   <= 1'b1;
                            m_byte  <= nxt_byte;
                            m_start <= 1'b1;
                            m_stop  <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end else if (tcnt == TC_LAST) begin
                        state <= ST_ERR;
                        err   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_cmd_sequencer.md
I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'b0001101, the 7-bit I2C target address.
REQ-002 The block SHALL have parameter MAX_RETRY, default 2, the number of re-sends allowed after a NACK.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 100000, the maximum number of cycles to wait for m_done per byte.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_in  in  66  command frame {op[1:0], opA[31:0], opB[31:0]}.
REQ-007 cmd_valid  in  1  cmd_in valid.
REQ-008 cmd_ready  out  1  sequencer can accept a command.
REQ-009 m_req  out  1  one-cycle request to the byte-level I2C master.
REQ-010 m_byte  out  8  byte to transmit; valid while m_req=1.
REQ-011 m_start  out  1  generate START before m_byte; qualified by m_req.
REQ-012 m_stop  out  1  generate STOP after m_byte; qualified by m_req.
REQ-013 m_done  in  1  one-cycle pulse: the byte has finished (ACK sampled).
REQ-014 m_nack  in  1  the target NACKed; valid only with m_done.
REQ-015 done  out  1  one-cycle pulse: frame sent successfully.
REQ-016 err  out  1  one-cycle pulse: frame abandoned.
REQ-017 st  out  4  current state encoding, for LEDs.
REQ-018 op  out  2  op field of the latched command.

Function
REQ-019 Handshake: a command SHALL be accepted on a cycle where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 only in IDLE.
REQ-020 Latching: on acceptance, cmd_in SHALL be latched, the byte index idx reset to 0 and the retry count reset to 0.
REQ-021 Frame: the frame SHALL be 10 bytes:
  - idx0 = {SLAVE_ADDR,1'b0}
  - idx1 = {6'b0,op}
  - idx2..5 = opA, MSB byte first
  - idx6..9 = opB, MSB byte first
REQ-022 Start/stop marking: m_start SHALL be 1 only for idx0; m_stop SHALL be 1 only for idx9.
REQ-023 States: IDLE=0, ISSUE=1, WAIT=2, DONE=3, ERR=4; st SHALL equal the state.
REQ-024 ISSUE: the block SHALL assert m_req for exactly one cycle with the m_byte, m_start and m_stop of the current idx, then go to WAIT.
REQ-025 WAIT, ACK: on m_done=1 with m_nack=0, if idx<9 the block SHALL increment idx and go to ISSUE; if idx=9 it SHALL go to DONE.
REQ-026 WAIT, NACK: on m_done=1 with m_nack=1, if retries<MAX_RETRY the block SHALL increment retries, set idx=0 and go to ISSUE; otherwise it SHALL go to ERR.
REQ-027 Timeout: in WAIT, a cycle counter SHALL run from 0; when it reaches TIMEOUT_CYC-1 without m_done, the block SHALL go to ERR with no retry.
REQ-028 Timeout reset: the cycle counter SHALL clear on every entry to WAIT.
REQ-029 DONE: done SHALL pulse for one cycle, then the block SHALL return to IDLE.
REQ-030 ERR: err SHALL pulse for one cycle, then the block SHALL return to IDLE.
REQ-031 done and err SHALL never be asserted together.
REQ-032 m_done arriving in any state other than WAIT SHALL be ignored.
REQ-033 A coincident m_done and timeout terminal count SHALL be treated as m_done.
REQ-034 cmd_valid outside IDLE SHALL be ignored, and the latched command SHALL NOT change.
REQ-035 Latency: the first m_req SHALL occur 1 cycle after acceptance, and done SHALL occur 1 cycle after the final m_done.
REQ-036 op SHALL hold the latched op until the next acceptance.

Reset
REQ-037 reset SHALL force IDLE, idx=0, retries=0 and timeout counter=0, and clear the latched command.
REQ-038 reset SHALL drive m_req, m_start, m_stop, done and err to 0 and m_byte to 8'h00; cmd_ready SHALL be 1 after reset; st=0; op=0.
REQ-039 reset mid-frame SHALL abort without emitting m_stop; bus recovery belongs to the I2C master.

Structure
REQ-040 The state encodings, FRAME_BYTES=10 and the default SLAVE_ADDR SHALL live in a shared package, i2c_seq_pkg.
REQ-041 Byte selection from the latched frame by idx SHALL be one combinational sub-module, frame_byte_mux.

Verification
REQ-042 Nominal: cmd_in={2'b01,32'h40A00000,32'h40400000}, all ACK -> m_byte sequence 1A,01,40,A0,00,00,40,40,00,00 with m_start on the first byte only, m_stop on the last byte only, then one done pulse.
REQ-043 NACK recovery: NACK on idx3 once -> the sequence restarts at 1A with retries=1, the full frame then completes and done pulses.
REQ-044 NACK exhaustion: NACK on idx0 three times (MAX_RETRY=2) -> exactly 3 m_req pulses, then err pulses, IDLE is reached, and done is never asserted.
REQ-045 Timeout: with TIMEOUT_CYC=16 and m_done withheld -> err pulses exactly 16 cycles after the WAIT entry.
REQ-046 Busy and reset: cmd_valid held high during a frame -> only one acceptance; reset asserted in WAIT at idx5 -> next cycle st=0, cmd_ready=1, no done/err.
